// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter for icache, load-miss and store requests onto one memory port, with a
// store-credit limit and fence drain. Optional store-stall counter: MEM_REQ_ARB_STALL_CNT_EN.
module mem_req_arbiter #(
    parameter int unsigned NrOutstandingStores = 7,
    parameter int unsigned AddrWidth           = 64,
    parameter int unsigned DataWidth           = 64,
    localparam int unsigned BeWidth            = DataWidth / 8,
    localparam int unsigned CntWidth           = $clog2(NrOutstandingStores + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ic_req_i,
    output logic                 ic_gnt_o,
    input  logic [AddrWidth-1:0] ic_addr_i,
    input  logic                 ld_req_i,
    output logic                 ld_gnt_o,
    input  logic [AddrWidth-1:0] ld_addr_i,
    input  logic                 st_req_i,
    output logic                 st_gnt_o,
    input  logic [AddrWidth-1:0] st_addr_i,
    input  logic [DataWidth-1:0] st_data_i,
    input  logic [BeWidth-1:0]   st_be_i,
    input  logic                 st_ack_i,
    input  logic                 fence_req_i,
    output logic                 fence_done_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [1:0]           mem_type_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_data_o,
    output logic [BeWidth-1:0]   mem_be_o,
    output logic [CntWidth-1:0]  outstanding_st_o,
    output logic [31:0]          st_stall_cnt_o
);

    typedef enum logic [1:0] {StIdle, StLocked, StFence} state_e;

    localparam logic [1:0] ReqIc = 2'd0;
    localparam logic [1:0] ReqLd = 2'd1;
    localparam logic [1:0] ReqSt = 2'd2;
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NrOutstandingStores);

    state_e                state_q, state_d;
    logic [1:0]            rr_q, rr_d;
    logic [1:0]            sel_q, sel_d;
    logic                  fence_pend_q, fence_pend_d;
    logic [CntWidth-1:0]   st_cnt_q, st_cnt_d;

    logic       st_full, fence_block, st_elig, any_elig;
    logic [1:0] arb_sel, cur_sel;
    logic       req, grant;

    function automatic logic [1:0] rr_next(input logic [1:0] s);
        return (s == ReqSt) ? ReqIc : s + 2'd1;
    endfunction

    assign st_full     = (st_cnt_q >= MaxCnt);
    assign fence_block = fence_pend_q || (state_q == StFence) ||
                         ((state_q == StIdle) && fence_req_i);
    assign st_elig     = st_req_i && !st_full && !fence_block;
    assign any_elig    = ic_req_i || ld_req_i || st_elig;

    always_comb begin
        arb_sel = ReqIc;
        unique case (rr_q)
            ReqLd:   arb_sel = ld_req_i ? ReqLd : (st_elig ? ReqSt : ReqIc);
            ReqSt:   arb_sel = st_elig ? ReqSt : (ic_req_i ? ReqIc : ReqLd);
            default: arb_sel = ic_req_i ? ReqIc : (ld_req_i ? ReqLd : ReqSt);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        sel_d        = sel_q;
        fence_pend_d = fence_pend_q;
        req          = 1'b0;
        cur_sel      = sel_q;
        fence_done_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fence_req_i) begin
                    state_d = StFence;
                end else if (any_elig) begin
                    req     = 1'b1;
                    cur_sel = arb_sel;
                    if (mem_gnt_i) begin
                        rr_d = rr_next(arb_sel);
                    end else begin
                        sel_d   = arb_sel;
                        state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                req = 1'b1;
                if (mem_gnt_i) begin
                    rr_d         = rr_next(sel_q);
                    fence_pend_d = 1'b0;
                    state_d      = (fence_pend_q || fence_req_i) ? StFence : StIdle;
                end else begin
                    fence_pend_d = fence_pend_q || fence_req_i;
                end
            end
            StFence: begin
                if (st_cnt_q == '0) begin
                    fence_done_o = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Gate with reset so a held request cannot reach the port while reset is asserted.
    assign mem_req_o  = req && rst_ni;
    assign grant      = mem_req_o && mem_gnt_i;
    assign ic_gnt_o   = grant && (cur_sel == ReqIc);
    assign ld_gnt_o   = grant && (cur_sel == ReqLd);
    assign st_gnt_o   = grant && (cur_sel == ReqSt);
    assign mem_type_o = cur_sel;

    always_comb begin
        mem_addr_o = ic_addr_i;
        mem_data_o = '0;
        mem_be_o   = '0;
        unique case (cur_sel)
            ReqLd: mem_addr_o = ld_addr_i;
            ReqSt: begin
                mem_addr_o = st_addr_i;
                mem_data_o = st_data_i;
                mem_be_o   = st_be_i;
            end
            default: mem_addr_o = ic_addr_i;
        endcase
    end

    always_comb begin
        st_cnt_d = st_cnt_q;
        if (st_gnt_o && !(st_ack_i && (st_cnt_q != '0))) begin
            st_cnt_d = st_cnt_q + CntWidth'(1);
        end else if (!st_gnt_o && st_ack_i && (st_cnt_q != '0)) begin
            st_cnt_d = st_cnt_q - CntWidth'(1);
        end
    end

    assign outstanding_st_o = st_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            rr_q         <= ReqIc;
            sel_q        <= ReqIc;
            fence_pend_q <= 1'b0;
            st_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            sel_q        <= sel_d;
            fence_pend_q <= fence_pend_d;
            st_cnt_q     <= st_cnt_d;
        end
    end

`ifdef MEM_REQ_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (st_req_i && (st_full || fence_block) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign st_stall_cnt_o = stall_cnt_q;
`else
    assign st_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: a spec-level model predicts grants per cycle and queues
// them; a monitor pops on every DUT grant and checks per-cycle port state.
module tb_mem_req_arbiter;
    localparam int NrSt = 7;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        ic_req, ld_req, st_req, st_ack, fence_req, mem_gnt;
    logic [63:0] ic_addr, ld_addr, st_addr, st_data;
    logic [7:0]  st_be;
    logic        ic_gnt, ld_gnt, st_gnt, fence_done, mem_req;
    logic [1:0]  mem_type;
    logic [63:0] mem_addr, mem_data;
    logic [7:0]  mem_be;
    logic [2:0]  outstanding;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    mem_req_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ic_req_i(ic_req), .ic_gnt_o(ic_gnt), .ic_addr_i(ic_addr),
        .ld_req_i(ld_req), .ld_gnt_o(ld_gnt), .ld_addr_i(ld_addr),
        .st_req_i(st_req), .st_gnt_o(st_gnt), .st_addr_i(st_addr),
        .st_data_i(st_data), .st_be_i(st_be), .st_ack_i(st_ack),
        .fence_req_i(fence_req), .fence_done_o(fence_done),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_type_o(mem_type),
        .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_be_o(mem_be),
        .outstanding_st_o(outstanding), .st_stall_cnt_o(stall_cnt)
    );

    typedef struct {
        int          who;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } txn_t;

    txn_t sb_q[$];
    int   got_log[$];
    int   done_log[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Reference model state: values after the coming clock edge.
    int          m_ptr, m_lock, m_cnt;
    bit          m_fence, m_fpend;
    logic [31:0] m_stall;
    // Expectations for the current cycle.
    bit          exp_valid = 0;
    bit          exp_req, exp_done;
    int          exp_sel, exp_who, exp_cnt;
    logic [31:0] exp_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] req_addr(input int w);
        if (w == 0) return ic_addr;
        if (w == 1) return ld_addr;
        return st_addr;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_lock = -1; m_cnt = 0; m_fence = 0; m_fpend = 0; m_stall = '0;
    endtask

    task automatic model_eval();
        int  cand, who;
        bit  f_blk, st_ok;
        cand = -1; who = -1;
        exp_req = 0; exp_done = 0;
        exp_cnt = m_cnt;
        exp_stall = m_stall;
        f_blk = m_fence || m_fpend || (m_lock < 0 && fence_req);
        st_ok = st_req && (m_cnt < NrSt) && !f_blk;
        if (m_fence) begin
            if (m_cnt == 0) begin
                exp_done = 1;
                m_fence  = 0;
            end
        end else if (m_lock >= 0) begin
            exp_req = 1;
            cand = m_lock;
            if (mem_gnt) begin
                who = m_lock;
                m_lock = -1;
                if (m_fpend || fence_req) m_fence = 1;
                m_fpend = 0;
            end else begin
                m_fpend = m_fpend || fence_req;
            end
        end else if (fence_req) begin
            m_fence = 1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                int j;
                j = (m_ptr + k) % 3;
                if (cand < 0 && ((j == 0 && ic_req) || (j == 1 && ld_req) || (j == 2 && st_ok)))
                    cand = j;
            end
            if (cand >= 0) begin
                exp_req = 1;
                if (mem_gnt) who = cand;
                else m_lock = cand;
            end
        end
        if (who >= 0) begin
            txn_t t;
            m_ptr = (who + 1) % 3;
            t.who  = who;
            t.addr = req_addr(who);
            t.data = (who == 2) ? st_data : 64'h0;
            t.be   = (who == 2) ? st_be : 8'h0;
            sb_q.push_back(t);
        end
        if (who == 2) m_cnt++;
        if (st_ack && exp_cnt > 0) m_cnt--;
`ifdef MEM_REQ_ARB_STALL_CNT_EN
        if (st_req && (exp_cnt >= NrSt || f_blk) && m_stall != 32'hFFFF_FFFF) m_stall++;
`else
        exp_stall = '0;
`endif
        exp_sel = cand;
        exp_who = who;
        exp_valid = 1;
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic step();
        cyc++;
        model_eval();
        @(posedge clk);
        @(negedge clk);
        st_ack = 0;
        fence_req = 0;
    endtask

    always @(negedge clk) begin
        #2;
        if (exp_valid) begin
            logic [2:0] eg;
            exp_valid = 0;
            eg = (exp_who >= 0) ? 3'(1 << exp_who) : 3'b000;
            chk("mem_req", 64'(mem_req), 64'(exp_req));
            chk("gnt_vec", 64'({st_gnt, ld_gnt, ic_gnt}), 64'(eg));
            chk("fence_done", 64'(fence_done), 64'(exp_done));
            chk("outstanding", 64'(outstanding), 64'(exp_cnt));
            chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
            if (exp_req) begin
                chk("sel_type", 64'(mem_type), 64'(exp_sel));
                chk("sel_addr", mem_addr, req_addr(exp_sel));
            end
            if (ic_gnt || ld_gnt || st_gnt) begin
                int g;
                g = ic_gnt ? 0 : (ld_gnt ? 1 : 2);
                got_log.push_back(g);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_grant: got requester %0d expected none", g);
                end else begin
                    txn_t t;
                    t = sb_q.pop_front();
                    chk("sb_who", 64'(g), 64'(t.who));
                    chk("sb_type", 64'(mem_type), 64'(t.who));
                    chk("sb_addr", mem_addr, t.addr);
                    chk("sb_data", mem_data, t.data);
                    chk("sb_be", 64'(mem_be), 64'(t.be));
                end
            end
            if (fence_done) done_log.push_back(cyc);
        end
    end

    initial begin
        int c0;
        rst_ni = 0;
        {ic_req, ld_req, st_req, st_ack, fence_req} = '0;
        mem_gnt = 1;
        ic_addr = 64'h1000; ld_addr = 64'h2000; st_addr = 64'h3000;
        st_data = 64'hDEAD_BEEF_0000_0001; st_be = 8'hF0;
        model_reset();
        ic_req = 1;
        #12;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_ic_gnt", 64'(ic_gnt), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_fence_done", 64'(fence_done), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        ic_req = 0;
        @(negedge clk);
        rst_ni = 1;
        step();

        // All three requesting with immediate grants: ic, ld, st, ic.
        ic_req = 1; ld_req = 1; st_req = 1; mem_gnt = 1;
        got_log.delete();
        for (int i = 0; i < 4; i++) step();
        chk("rr_n", 64'(got_log.size()), 64'd4);
        chk("rr_0", 64'(got_log.size() > 0 ? got_log[0] : -1), 64'd0);
        chk("rr_1", 64'(got_log.size() > 1 ? got_log[1] : -1), 64'd1);
        chk("rr_2", 64'(got_log.size() > 2 ? got_log[2] : -1), 64'd2);
        chk("rr_3", 64'(got_log.size() > 3 ? got_log[3] : -1), 64'd0);
        ic_req = 0; ld_req = 0; st_req = 0;
        st_ack = 1;
        step();

        // Load held in LOCKED for 3 cycles; icache joins in cycle 2.
        got_log.delete();
        ld_req = 1; ld_addr = 64'hABCD_0040; mem_gnt = 0;
        step();
        ic_req = 1; ic_addr = 64'h1111_0080;
        step();
        step();
        mem_gnt = 1;
        step();
        if (got_log.size() > 0 && got_log[0] == 1) ld_req = 0;
        step();
        ic_req = 0;
        chk("lock_n", 64'(got_log.size()), 64'd2);
        chk("lock_ld_first", 64'(got_log.size() > 0 ? got_log[0] : -1), 64'd1);
        chk("lock_ic_next", 64'(got_log.size() > 1 ? got_log[1] : -1), 64'd0);

        // Store credit exhaustion: 7 grants, then stall until one ack.
        got_log.delete();
        st_req = 1; mem_gnt = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (exp_who == 2) begin st_addr = st_addr + 64'h40; st_data = {$urandom, $urandom}; end
        end
        chk("credit_grants", 64'(got_log.size()), 64'd7);
        chk("credit_outstanding", 64'(outstanding), 64'd7);
`ifdef MEM_REQ_ARB_STALL_CNT_EN
        chk("credit_stall", 64'(stall_cnt), 64'd3);
`else
        chk("credit_stall", 64'(stall_cnt), 64'd0);
`endif
        st_ack = 1;
        step();
        chk("credit_still_blocked", 64'(got_log.size()), 64'd7);
        step();
        chk("credit_8th_granted", 64'(got_log.size()), 64'd8);
        st_req = 0;
        for (int i = 0; i < 4; i++) begin st_ack = 1; step(); end
        chk("pre_fence_cnt", 64'(outstanding), 64'd3);

        // Fence with 3 outstanding; acks at cycles 2, 5, 6; done at cycle 7.
        got_log.delete(); done_log.delete();
        ic_req = 1; ic_addr = 64'h5555_0000; mem_gnt = 1;
        c0 = cyc + 1;
        fence_req = 1;
        step();
        for (int c = 1; c <= 7; c++) begin
            st_ack = (c == 2 || c == 5 || c == 6);
            step();
        end
        chk("fence_no_grants", 64'(got_log.size()), 64'd0);
        chk("fence_done_once", 64'(done_log.size()), 64'd1);
        chk("fence_done_cycle", 64'(done_log.size() > 0 ? done_log[0] - c0 : -1), 64'd7);
        step();
        chk("post_fence_ic", 64'(got_log.size() == 1 && got_log[0] == 0), 64'd1);
        ic_req = 0;

        // Simultaneous grant and ack at count 5; ack at zero.
        st_req = 1;
        for (int i = 0; i < 5; i++) begin st_addr = st_addr + 64'h40; step(); end
        chk("cnt_five", 64'(outstanding), 64'd5);
        st_ack = 1;
        step();
        chk("cnt_grant_ack", 64'(outstanding), 64'd5);
        st_req = 0;
        for (int i = 0; i < 5; i++) begin st_ack = 1; step(); end
        chk("cnt_zero", 64'(outstanding), 64'd0);
        st_ack = 1;
        step();
        chk("cnt_no_underflow", 64'(outstanding), 64'd0);

        // Reset during LOCKED, then during FENCE.
        ld_req = 1; mem_gnt = 0;
        step();
        #3 rst_ni = 0;
        #1;
        chk("rst_locked_mem_req", 64'(mem_req), 64'd0);
        chk("rst_locked_gnt", 64'({ic_gnt, ld_gnt, st_gnt}), 64'd0);
        @(negedge clk);
        ld_req = 0;
        model_reset();
        rst_ni = 1;
        for (int i = 0; i < 3; i++) step();
        chk("post_rst_cnt", 64'(outstanding), 64'd0);
        st_req = 1; mem_gnt = 1;
        step();
        st_req = 0; fence_req = 1;
        step();
        step();
        #3 rst_ni = 0;
        @(negedge clk);
        model_reset();
        rst_ni = 1;
        done_log.delete();
        for (int i = 0; i < 3; i++) step();
        chk("rst_fence_no_done", 64'(done_log.size()), 64'd0);

        // Randomized traffic under the same model.
        for (int n = 0; n < 3000; n++) begin
            mem_gnt   = ($urandom_range(0, 9) < 6);
            st_ack    = ($urandom_range(0, 3) == 0);
            fence_req = ($urandom_range(0, 59) == 0);
            if (!ic_req && $urandom_range(0, 2) == 0) begin
                ic_req = 1; ic_addr = {$urandom, $urandom};
            end
            if (!ld_req && $urandom_range(0, 2) == 0) begin
                ld_req = 1; ld_addr = {$urandom, $urandom};
            end
            if (!st_req && $urandom_range(0, 1) == 0) begin
                st_req = 1; st_addr = {$urandom, $urandom};
                st_data = {$urandom, $urandom}; st_be = 8'($urandom);
            end
            step();
            if (exp_who == 0) ic_req = 0;
            if (exp_who == 1) ld_req = 0;
            if (exp_who == 2) st_req = 0;
        end
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter NrOutstandingStores, default 7, max stores issued but not yet acknowledged.
REQ-002 Parameter AddrWidth, default 64, request address width.
REQ-003 Parameter DataWidth, default 64, store data width; byte-enable width is DataWidth/8.
REQ-004 clk_i  in  1  single clock; all state rising-edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 ic_req_i / ic_gnt_o / ic_addr_i  in/out/in  1/1/AddrWidth  icache refill request.
REQ-007 ld_req_i / ld_gnt_o / ld_addr_i  in/out/in  1/1/AddrWidth  dcache load-miss request.
REQ-008 st_req_i / st_gnt_o / st_addr_i / st_data_i / st_be_i  in/out/in/in/in  1/1/AddrWidth/DataWidth/DataWidth/8  write-buffer store request.
REQ-009 st_ack_i  in  1  one-cycle pulse; one store completed downstream.
REQ-010 fence_req_i / fence_done_o  in/out  1/1  drain request; one-cycle completion pulse.
REQ-011 mem_req_o / mem_gnt_i  out/in  1/1  request to memory port.
REQ-012 mem_type_o  out  2  0 = ifetch, 1 = load, 2 = store; 3 is never driven.
REQ-013 mem_addr_o / mem_data_o / mem_be_o  out  AddrWidth/DataWidth/DataWidth/8  payload of the selected requester; data and be are 0 unless type = store.
REQ-014 outstanding_st_o  out  $clog2(NrOutstandingStores+1)  current unacknowledged store count.
REQ-015 st_stall_cnt_o  out  32  store-stall cycle count (see Configuration).

Function
REQ-016 Requesters SHALL hold req and payload stable until their gnt; gnt_o = mem_req_o && mem_gnt_i && (selected == requester), combinational.
REQ-017 FSM states: IDLE, LOCKED, FENCE.
REQ-018 IDLE: the arbiter SHALL select among eligible requesters by round-robin (order ic -> ld -> st) and drive mem_req_o in the same cycle.
REQ-019 The round-robin pointer SHALL advance to one past the granted requester only on a grant.
REQ-020 IDLE, request not granted in the same cycle: the arbiter SHALL register the selection and enter LOCKED.
REQ-021 LOCKED: mem_req_o = 1 with the locked requester's payload; on mem_gnt_i, return to IDLE; arbitration is frozen.
REQ-022 A store is eligible only if outstanding_st_o < NrOutstandingStores and no fence is pending.
REQ-023 The counter SHALL +1 on store grant and -1 on st_ack_i; both in the same cycle leaves it unchanged; st_ack_i at 0 is ignored (no underflow).
REQ-024 fence_req_i sampled in IDLE: enter FENCE; sampled in LOCKED: finish the locked grant first, then enter FENCE.
REQ-025 FENCE: no grants; mem_req_o = 0; when the counter is 0, pulse fence_done_o for one cycle and return to IDLE.
REQ-026 Fence entered with counter already 0: fence_done_o SHALL pulse on the cycle after FENCE entry.
REQ-027 No requester eligible: mem_req_o = 0 and all gnt_o = 0.

Reset
REQ-028 On rst_ni low, asynchronously: state = IDLE; RR pointer = ic; counter = 0; fence_done_o = 0; st_stall_cnt_o = 0; all gnt_o = 0; mem_req_o = 0.
REQ-029 Reset mid-LOCKED or mid-FENCE SHALL abandon the transaction; no grant or fence_done_o pulse follows reset release unless newly requested.

Configuration
REQ-030 Macro MEM_REQ_ARB_STALL_CNT_EN.
- Defined: st_stall_cnt_o increments, saturating at 32'hFFFF_FFFF, on every cycle with st_req_i = 1 and the store ineligible per REQ-022.
- Undefined: st_stall_cnt_o tied to 0 and no counter flops are instantiated.
- Arbitration behaviour is identical either way.

Verification
REQ-031 All three requests high in IDLE, mem_gnt_i = 1 each cycle -> grants ic, ld, st, ic in consecutive cycles; mem_type_o = 0, 1, 2, 0.
REQ-032 ld_req_i high, mem_gnt_i low for 3 cycles, ic_req_i asserted in cycle 2 -> ld stays selected in LOCKED with mem_addr_o stable; ld_gnt_o on cycle 4; ic granted next.
REQ-033 8 back-to-back stores, no st_ack_i -> 7 grants, outstanding_st_o = 7, 8th stalled (st_stall_cnt_o increments with macro); one st_ack_i -> 8th granted the following cycle.
REQ-034 Counter = 3, fence_req_i high, 3 st_ack_i pulses at cycles 2, 5, 6 -> no grants throughout; fence_done_o pulses exactly once, at cycle 7.
REQ-035 Store grant and st_ack_i in the same cycle at count 5 -> count stays 5; st_ack_i at count 0 -> count stays 0.
REQ-036 rst_ni low during LOCKED -> mem_req_o = 0 immediately; after release with no requests, mem_req_o remains 0 and the counter is 0.
